// File: rtl/hpdcache_pkg.sv
// Minimal slice of the HPDcache package: only the cache-line address type
// consumed by the stride prefetch engine.
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_NLINE_WIDTH = 26;

  typedef logic [HPDCACHE_NLINE_WIDTH-1:0] hpdcache_nline_t;

endpackage

// File: rtl/hwpf_stride_pkg.sv
// Shared types and helpers for the stride prefetcher (snooper + engine).
package hwpf_stride_pkg;

  import hpdcache_pkg::*;

  localparam int unsigned HWPF_NBLOCKS_WIDTH = 4;
  localparam int unsigned HWPF_STRIDE_WIDTH  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } hwpf_stride_state_e;

  typedef struct packed {
    logic                          en;
    logic [HWPF_STRIDE_WIDTH-1:0]  stride;
    logic [HWPF_NBLOCKS_WIDTH-1:0] nblocks;
  } hwpf_stride_cfg_t;

  // Line addresses wrap modulo the line-address width; the stride is zero-extended.
  function automatic hpdcache_nline_t nline_add(input hpdcache_nline_t a,
                                                input logic [HWPF_STRIDE_WIDTH-1:0] s);
    return a + hpdcache_nline_t'(s);
  endfunction

endpackage

// File: rtl/hwpf_stride_engine.sv
// Stride prefetch request generator: on each snooper match it issues a burst of
// line requests at base+k*stride, then slides the base forward by one stride.
module hwpf_stride_engine
  import hpdcache_pkg::*;
  import hwpf_stride_pkg::*;
#(
  parameter int unsigned NBLOCKS_WIDTH = HWPF_NBLOCKS_WIDTH,
  parameter int unsigned STRIDE_WIDTH  = HWPF_STRIDE_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_en_i,
  input  logic                     cfg_base_set_i,
  input  hpdcache_nline_t          cfg_base_nline_i,
  input  logic [STRIDE_WIDTH-1:0]  cfg_stride_i,
  input  logic [NBLOCKS_WIDTH-1:0] cfg_nblocks_i,
  input  logic                     snoop_match_i,
  output logic                     snooper_en_o,
  output hpdcache_nline_t          base_nline_o,
  output logic                     req_valid_o,
  input  logic                     req_ready_i,
  output hpdcache_nline_t          req_nline_o,
  output logic                     busy_o
);

  hwpf_stride_state_e       state_q, state_d;
  hpdcache_nline_t          base_q, base_d;
  hpdcache_nline_t          next_q, next_d;
  logic [NBLOCKS_WIDTH-1:0] cnt_q, cnt_d;
  logic [STRIDE_WIDTH-1:0]  stride_q, stride_d;
  logic                     abort_q, abort_d;
  hwpf_stride_cfg_t         cfg_s;

  assign cfg_s = '{en: cfg_en_i, stride: cfg_stride_i, nblocks: cfg_nblocks_i};

  // The snooper only runs while idle; the reset term keeps it quiet while held in reset.
  assign snooper_en_o = cfg_s.en & rst_ni & (state_q == IDLE);
  assign base_nline_o = base_q;
  assign req_valid_o  = (state_q == ISSUE);
  assign busy_o       = (state_q == ISSUE);
  assign req_nline_o  = next_q;

  // Next-state logic: trigger handling in IDLE, handshake bookkeeping in ISSUE.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    next_d   = next_q;
    cnt_d    = cnt_q;
    stride_d = stride_q;
    abort_d  = abort_q;
    case (state_q)
      IDLE: begin
        if (cfg_base_set_i) begin
          base_d = cfg_base_nline_i;
        end else if (cfg_s.en && snoop_match_i) begin
          if (cfg_s.nblocks == '0) begin
            base_d = nline_add(base_q, cfg_s.stride);
          end else begin
            cnt_d    = cfg_s.nblocks;
            next_d   = nline_add(base_q, cfg_s.stride);
            stride_d = cfg_s.stride;
            abort_d  = 1'b0;
            state_d  = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // A disable seen at any point of the burst ends it after the pending handshake.
        abort_d = abort_q | ~cfg_en_i;
        if (req_ready_i) begin
          cnt_d  = cnt_q - NBLOCKS_WIDTH'(1);
          next_d = nline_add(next_q, stride_q);
          if (abort_d) begin
            state_d = IDLE;
          end else if (cnt_q == NBLOCKS_WIDTH'(1)) begin
            base_d  = nline_add(base_q, stride_q);
            state_d = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      base_q   <= '0;
      next_q   <= '0;
      cnt_q    <= '0;
      stride_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      next_q   <= next_d;
      cnt_q    <= cnt_d;
      stride_q <= stride_d;
      abort_q  <= abort_d;
    end
  end

endmodule
